// File: rtl/commit_if.sv
// commit_if: ROB-head retirement inputs and architectural-effect outputs of the commit stage
interface commit_if;
   logic        in_valid;
   logic [31:0] in_value;
   logic [4:0]  in_rd;
   logic [31:0] in_PC;
   logic [31:0] in_miss_addr;
   logic [2:0]  in_exception;
   logic [2:0]  in_instr_type;
   logic        out_rf_we;
   logic [4:0]  out_rf_rd;
   logic [31:0] out_rf_value;
   logic        out_store_commit;
   logic        out_flush;
   logic        out_redirect;
   logic [31:0] out_redirect_PC;
   logic [31:0] out_rm0;
   logic [31:0] out_rm1;
   logic [2:0]  out_rm2;
   logic        out_busy;
   logic [31:0] out_instret;
   modport master (
      output in_valid, in_value, in_rd, in_PC, in_miss_addr, in_exception, in_instr_type,
      input  out_rf_we, out_rf_rd, out_rf_value, out_store_commit, out_flush, out_redirect,
             out_redirect_PC, out_rm0, out_rm1, out_rm2, out_busy, out_instret
   );
   modport slave (
      input  in_valid, in_value, in_rd, in_PC, in_miss_addr, in_exception, in_instr_type,
      output out_rf_we, out_rf_rd, out_rf_value, out_store_commit, out_flush, out_redirect,
             out_redirect_PC, out_rm0, out_rm1, out_rm2, out_busy, out_instret
   );
endinterface

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement with exception capture, pipeline flush and fetch redirect
module commit_unit #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_2000,
   parameter int          FLUSH_CYCLES = 2
) (
   input logic     clk,
   input logic     reset,
   commit_if.slave bus
);
   typedef enum logic [1:0] {RUN, FLUSH, REDIRECT} state_t;
   state_t      state, next_state;
   logic [3:0]  cnt, cnt_n;
   logic        retire, fault, rf_we_n, store_n;
   logic        rf_we, store_commit, flush, redirect, busy;
   logic [4:0]  rf_rd;
   logic [31:0] rf_value, redirect_pc, rm0, rm1, instret;
   logic [2:0]  rm2;
   // state register plus every output, registered so effects land one cycle after the entry
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state        <= RUN;
         cnt          <= '0;
         rf_we        <= 1'b0;
         rf_rd        <= '0;
         rf_value     <= '0;
         store_commit <= 1'b0;
         flush        <= 1'b0;
         redirect     <= 1'b0;
         redirect_pc  <= '0;
         busy         <= 1'b0;
         rm0          <= '0;
         rm1          <= '0;
         rm2          <= '0;
         instret      <= '0;
      end else begin
         state        <= next_state;
         cnt          <= cnt_n;
         rf_we        <= rf_we_n;
         rf_rd        <= bus.in_rd;
         rf_value     <= bus.in_value;
         store_commit <= store_n;
         flush        <= next_state == FLUSH;
         redirect     <= next_state == REDIRECT;
         redirect_pc  <= next_state == REDIRECT ? EXC_VECTOR : '0;
         busy         <= next_state != RUN;
         instret      <= instret + {31'b0, retire};
         if (fault) begin
            rm0 <= bus.in_PC;
            rm1 <= bus.in_miss_addr;
            rm2 <= bus.in_exception;
         end
      end
   // next state: the flush counter starts one below the hold length so the redirect lands on time
   always_comb begin
      next_state = state;
      cnt_n      = cnt;
      if (state == RUN) begin
         if (fault) begin
            next_state = FLUSH;
            cnt_n      = 4'(FLUSH_CYCLES - 1);
         end
      end else if (state == FLUSH) begin
         if (cnt == 4'd0) next_state = REDIRECT;
         else cnt_n = cnt - 4'd1;
      end else next_state = RUN;
   end
   // entry decode: only entries presented in RUN have any effect; x0 is never written
   always_comb begin
      retire  = state == RUN && bus.in_valid && bus.in_exception == 3'd0;
      fault   = state == RUN && bus.in_valid && bus.in_exception != 3'd0;
      rf_we_n = retire && bus.in_instr_type <= 3'd2 && bus.in_rd != 5'd0;
      store_n = retire && bus.in_instr_type == 3'd3;
   end
   assign bus.out_rf_we        = rf_we;
   assign bus.out_rf_rd        = rf_rd;
   assign bus.out_rf_value     = rf_value;
   assign bus.out_store_commit = store_commit;
   assign bus.out_flush        = flush;
   assign bus.out_redirect     = redirect;
   assign bus.out_redirect_PC  = redirect_pc;
   assign bus.out_rm0          = rm0;
   assign bus.out_rm1          = rm1;
   assign bus.out_rm2          = rm2;
   assign bus.out_busy         = busy;
   assign bus.out_instret      = instret;
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed stimulus with a reference model feeding an expected-result queue
module tb_commit_unit;
   localparam logic [31:0] EXC = 32'h0000_2000;
   localparam int          FC  = 2;
   typedef struct {
      logic        we, st, fl, rdr, busy;
      logic [4:0]  rd;
      logic [31:0] val, rpc, instret, rm0, rm1;
      logic [2:0]  rm2;
   } exp_t;
   logic clk = 1'b0;
   logic reset;
   int tests = 0;
   int fails = 0;
   exp_t q[$];
   int m_state, m_cnt;
   logic [31:0] m_instret, m_rm0, m_rm1;
   logic [2:0]  m_rm2;
   commit_if bus();
   commit_unit #(.EXC_VECTOR(EXC), .FLUSH_CYCLES(FC)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_instret = '0; m_rm0 = '0; m_rm1 = '0; m_rm2 = '0;
      q.delete();
   endtask
   task automatic check();
      exp_t e;
      tests++;
      assert (q.size() > 0) else begin
         fails++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = q.pop_front();
      chk("rf_we", bus.out_rf_we, e.we);
      if (e.we) begin
         chk("rf_rd", bus.out_rf_rd, e.rd);
         chk("rf_value", bus.out_rf_value, e.val);
      end
      chk("store_commit", bus.out_store_commit, e.st);
      chk("flush", bus.out_flush, e.fl);
      chk("redirect", bus.out_redirect, e.rdr);
      chk("redirect_pc", bus.out_redirect_PC, e.rpc);
      chk("busy", bus.out_busy, e.busy);
      chk("instret", bus.out_instret, e.instret);
      chk("rm0", bus.out_rm0, e.rm0);
      chk("rm1", bus.out_rm1, e.rm1);
      chk("rm2", bus.out_rm2, e.rm2);
   endtask
   task automatic step(input logic v, input logic [2:0] t, input logic [4:0] rd, input logic [31:0] val,
                       input logic [2:0] exc, input logic [31:0] pc, input logic [31:0] miss);
      exp_t e;
      bus.in_valid = v; bus.in_instr_type = t; bus.in_rd = rd; bus.in_value = val;
      bus.in_exception = exc; bus.in_PC = pc; bus.in_miss_addr = miss;
      e = '{default: '0};
      e.rd = rd;
      e.val = val;
      if (m_state == 0 && v) begin
         if (exc == 3'd0) begin
            m_instret = m_instret + 32'd1;
            e.we = t <= 3'd2 && rd != 5'd0;
            e.st = t == 3'd3;
         end else begin
            m_rm0 = pc; m_rm1 = miss; m_rm2 = exc; m_state = 1; m_cnt = FC;
         end
      end else if (m_state == 1) begin
         m_cnt--;
         if (m_cnt == 0) m_state = 2;
      end else if (m_state == 2) m_state = 0;
      e.fl = m_state == 1;
      e.rdr = m_state == 2;
      e.busy = m_state != 0;
      e.rpc = e.rdr ? EXC : 32'd0;
      e.instret = m_instret;
      e.rm0 = m_rm0; e.rm1 = m_rm1; e.rm2 = m_rm2;
      q.push_back(e);
      @(posedge clk);
      #1;
      check();
   endtask
   task automatic idle();
      step(1'b0, 3'd0, 5'd0, 32'd0, 3'd0, 32'd0, 32'd0);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_rf_we"}, bus.out_rf_we, 1'b0);
      chk({tag, "_store"}, bus.out_store_commit, 1'b0);
      chk({tag, "_flush"}, bus.out_flush, 1'b0);
      chk({tag, "_redirect"}, bus.out_redirect, 1'b0);
      chk({tag, "_redirect_pc"}, bus.out_redirect_PC, 32'd0);
      chk({tag, "_busy"}, bus.out_busy, 1'b0);
      chk({tag, "_instret"}, bus.out_instret, 32'd0);
      chk({tag, "_rm0"}, bus.out_rm0, 32'd0);
      chk({tag, "_rm1"}, bus.out_rm1, 32'd0);
      chk({tag, "_rm2"}, bus.out_rm2, 3'd0);
   endtask
   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_instr_type = '0; bus.in_rd = '0; bus.in_value = '0;
      bus.in_exception = '0; bus.in_PC = '0; bus.in_miss_addr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 3'd0, 5'd5, 32'hDEAD_BEEF, 3'd0, 32'h10, 32'd0);
      step(1'b1, 3'd3, 5'd7, 32'h1234_5678, 3'd0, 32'h14, 32'd0);
      step(1'b1, 3'd2, 5'd0, 32'h5555_AAAA, 3'd0, 32'h18, 32'd0);
      idle();
      step(1'b1, 3'd1, 5'd31, 32'hFFFF_0001, 3'd0, 32'h1C, 32'd0);
      step(1'b1, 3'd4, 5'd6, 32'h0000_0042, 3'd0, 32'h20, 32'd0);
      step(1'b1, 3'd6, 5'd3, 32'h0000_0077, 3'd0, 32'h24, 32'd0);
      step(1'b1, 3'd2, 5'd12, 32'hCAFE_F00D, 3'd0, 32'h28, 32'd0);
      step(1'b1, 3'd0, 5'd8, 32'h1111_1111, 3'd2, 32'h100, 32'hABC0);
      step(1'b1, 3'd0, 5'd9, 32'h2222_2222, 3'd0, 32'h104, 32'd0);
      step(1'b1, 3'd3, 5'd9, 32'h3333_3333, 3'd4, 32'h108, 32'hFFF0);
      step(1'b1, 3'd0, 5'd10, 32'h4444_4444, 3'd0, 32'h10C, 32'd0);
      step(1'b1, 3'd0, 5'd11, 32'h5555_5555, 3'd0, 32'h2000, 32'd0);
      step(1'b1, 3'd0, 5'd2, 32'h6666_6666, 3'd5, 32'h200, 32'h0);
      idle();
      idle();
      idle();
      step(1'b1, 3'd3, 5'd0, 32'h0, 3'd0, 32'h2004, 32'd0);
      step(1'b1, 3'd0, 5'd1, 32'h7777_7777, 3'd1, 32'h300, 32'h3000);
      idle();
      #2;
      reset = 1'b1;
      #1;
      chk_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      idle();
      step(1'b1, 3'd0, 5'd4, 32'h0BAD_F00D, 3'd0, 32'h400, 32'd0);
      force dut.instret = 32'hFFFF_FFFF;
      m_instret = 32'hFFFF_FFFF;
      idle();
      release dut.instret;
      step(1'b1, 3'd0, 5'd1, 32'h0000_0001, 3'd0, 32'h404, 32'd0);
      step(1'b1, 3'd1, 5'd2, 32'h0000_0002, 3'd0, 32'h408, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
